// File: rtl/ring_pkg.sv
// Shared definitions for the ring channel and the progress checker benches:
// state encoding, default sizing constants and the debug view of the channel.
package ring_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_XMIT    = 2'd1;
   localparam logic [1:0] ST_BACKOFF = 2'd2;

   localparam int RING_DEPTH     = 4;
   localparam int RING_SEQ_W     = 3;
   localparam int RING_TIMEOUT   = 3;
   localparam int RING_MAX_RETRY = 2;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_XMIT    = ST_XMIT,
      S_BACKOFF = ST_BACKOFF
   } ring_state_e;

   typedef struct packed {
      ring_state_e state;
      logic        fifo_empty;
   } ring_dbg_t;

endpackage

// File: rtl/ring_channel_if.sv
// Node/environment side of the ring channel. Optional dup input exists only
// when RING_CHANNEL_DUP_EN is defined.
interface ring_channel_if
   import ring_pkg::*;
#(
   parameter int DEPTH = RING_DEPTH,
   parameter int SEQ_W = RING_SEQ_W
);
   // dlv_valid is a one-cycle strobe with no backpressure: a consumer must take
   // dlv_seq in every cycle dlv_valid is high; send/drop/dup are sampled each edge.
   logic                       send;
   logic                       drop;
`ifdef RING_CHANNEL_DUP_EN
   logic                       dup;
`endif
   logic                       loss;
   logic                       ring_reset;
   logic                       dlv_valid;
   logic [SEQ_W-1:0]           dlv_seq;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       full;
   logic                       error;
   ring_dbg_t                  dbg;

   modport master (
`ifdef RING_CHANNEL_DUP_EN
      output dup,
`endif
      output send, drop,
      input  loss, ring_reset, dlv_valid, dlv_seq, count, full, error, dbg
   );

   modport slave (
`ifdef RING_CHANNEL_DUP_EN
      input  dup,
`endif
      input  send, drop,
      output loss, ring_reset, dlv_valid, dlv_seq, count, full, error, dbg
   );

endinterface

// File: rtl/ring_fifo.sv
// Synchronous circular buffer with wrap-around pointers and a separate
// occupancy count; flush empties it in one cycle.
module ring_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ring_channel.sv
// Lossy in-order token channel feeding the ring progress checker. Define
// RING_CHANNEL_DUP_EN to add the dup (deliver-without-pop) input.
module ring_channel
   import ring_pkg::*;
#(
   parameter int DEPTH     = RING_DEPTH,
   parameter int SEQ_W     = RING_SEQ_W,
   parameter int TIMEOUT   = RING_TIMEOUT,
   parameter int MAX_RETRY = RING_MAX_RETRY
) (
   input  logic           clk,
   input  logic           reset,
   ring_channel_if.slave  bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   ring_state_e      state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic [SEQ_W-1:0] tail_seq_q;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic             loss_q, loss_d;
   logic             rr_q, rr_d;
   logic             dv_q, dv_d;
   logic             err_q, err_d;

   logic             push, pop, flush, dup_req;
   logic [SEQ_W-1:0] head_seq;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;

`ifdef RING_CHANNEL_DUP_EN
   assign dup_req = bus.dup;
`else
   assign dup_req = 1'b0;
`endif

   ring_fifo #(.DEPTH(DEPTH), .W(SEQ_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (tail_seq_q),
      .dout  (head_seq),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         retry_q    <= '0;
         tail_seq_q <= '0;
         seq_q      <= '0;
         loss_q     <= 1'b0;
         rr_q       <= 1'b0;
         dv_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         seq_q   <= seq_d;
         loss_q  <= loss_d;
         rr_q    <= rr_d;
         dv_q    <= dv_d;
         err_q   <= err_d;
         if (push) tail_seq_q <= tail_seq_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      retry_d = retry_q;
      seq_d   = seq_q;
      loss_d  = 1'b0;
      rr_d    = 1'b0;
      dv_d    = 1'b0;
      pop     = 1'b0;
      flush   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.send) state_d = S_XMIT;
         end
         S_XMIT: begin
            if (bus.drop) begin
               loss_d = 1'b1;
               if (int'(retry_q) + 1 < MAX_RETRY) begin
                  retry_d = retry_q + 1'b1;
                  timer_d = TMR_W'(TIMEOUT - 1);
                  state_d = S_BACKOFF;
               end else begin
                  // Retry budget exhausted: discard everything and restart the ring.
                  flush   = 1'b1;
                  retry_d = '0;
                  rr_d    = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               dv_d  = 1'b1;
               seq_d = head_seq;
               if (!dup_req) begin
                  pop     = 1'b1;
                  retry_d = '0;
                  if (fifo_count == CNT_W'(1) && !bus.send) state_d = S_IDLE;
               end
            end
         end
         S_BACKOFF: begin
            if (timer_q == '0) begin
               state_d = S_XMIT;
            end else begin
               loss_d  = 1'b1;
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
      push  = bus.send && !flush && (!fifo_full || pop);
      err_d = err_q || (bus.send && !push && !flush);
   end

   assign bus.loss       = loss_q;
   assign bus.ring_reset = rr_q;
   assign bus.dlv_valid  = dv_q;
   assign bus.dlv_seq    = seq_q;
   assign bus.count      = fifo_count;
   assign bus.full       = fifo_full;
   assign bus.error      = err_q;
   assign bus.dbg        = {state_q, fifo_empty};

endmodule

// File: tb/tb_ring_channel.sv
// Vector-table bench for ring_channel with a delivery scoreboard; covers the
// dup vectors too when RING_CHANNEL_DUP_EN is defined.
module tb_ring_channel;
   import ring_pkg::*;

   typedef struct {
      string      name;
      logic       rst;
      logic       send;
      logic       drop;
      logic       dup;
      logic       push_exp;
      logic [2:0] push_seq;
      logic       loss;
      logic       rr;
      logic       dv;
      logic [2:0] cnt;
      logic       full;
      logic       err;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   vec_t       vecs[$];
   logic [2:0] exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   ring_channel_if #(.DEPTH(4), .SEQ_W(3)) bus ();

   ring_channel #(.DEPTH(4), .SEQ_W(3), .TIMEOUT(3), .MAX_RETRY(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic r, input logic s, input logic d, input logic u,
                      input logic pe, input logic [2:0] ps, input logic l, input logic rr,
                      input logic dv, input logic [2:0] c, input logic f, input logic e);
      vec_t v;
      v.name = nm; v.rst = r; v.send = s; v.drop = d; v.dup = u;
      v.push_exp = pe; v.push_seq = ps; v.loss = l; v.rr = rr; v.dv = dv;
      v.cnt = c; v.full = f; v.err = e;
      vecs.push_back(v);
   endtask

   task automatic add_rst();
      add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bus.send = 1'b0;
      bus.drop = 1'b0;
`ifdef RING_CHANNEL_DUP_EN
      bus.dup = 1'b0;
`endif
      //   name        rst snd drp dup pe ps  loss rr dv cnt full err
      add_rst();
      add("basic",      0, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0);
      add("basic",      0, 1, 0, 0, 1, 1,  0, 0, 1, 1, 0, 0);
      add("basic",      0, 1, 0, 0, 1, 2,  0, 0, 1, 1, 0, 0);
      add("basic",      0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
      add("basic",      0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add_rst();
      add("backoff",    0, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0);
      add("backoff",    0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);
      add("backoff",    0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);
      add("backoff",    0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
      add("backoff",    0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
      add("backoff",    0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
      add("backoff",    0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add_rst();
      add("retry",      0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
      add("retry",      0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);
      add("retry",      0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
      add("retry",      0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
      add("retry",      0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
      add("retry_fl",   0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0);
      add("retry",      0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add("retry",      0, 1, 0, 0, 1, 1,  0, 0, 0, 1, 0, 0);
      add("retry",      0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
      add("retry",      0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add_rst();
      add("full",       0, 1, 1, 0, 1, 0,  0, 0, 0, 1, 0, 0);
      add("full",       0, 1, 1, 0, 1, 1,  1, 0, 0, 2, 0, 0);
      add("full",       0, 1, 1, 0, 1, 2,  1, 0, 0, 3, 0, 0);
      add("full",       0, 1, 1, 0, 1, 3,  1, 0, 0, 4, 1, 0);
      add("full_rej",   0, 1, 1, 0, 0, 0,  0, 0, 0, 4, 1, 1);
      add("full_pp",    0, 1, 0, 0, 1, 4,  0, 0, 1, 4, 1, 1);
      add("full",       0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0, 1);
      add("full",       0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0, 1);
      add("full",       0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1);
      add("full",       0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1);
      add("full",       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      add_rst();
      add("rst_bo",     0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
      add("rst_bo",     0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);
      add("rst_bo",     0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
      add_rst();
      add("rst_bo",     0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add("rst_bo",     0, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0);
      add("rst_bo",     0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
      add("rst_bo",     0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
`ifdef RING_CHANNEL_DUP_EN
      add_rst();
      add("dup",        0, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0);
      add("dup",        0, 0, 0, 1, 1, 0,  0, 0, 1, 1, 0, 0);
      add("dup",        0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
      add("dup",        0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         reset    = vecs[i].rst;
         bus.send = vecs[i].send;
         bus.drop = vecs[i].drop;
`ifdef RING_CHANNEL_DUP_EN
         bus.dup  = vecs[i].dup;
`endif
         if (vecs[i].push_exp) exp_q.push_back(vecs[i].push_seq);
         @(posedge clk);
         #1;
         check({vecs[i].name, ".loss"},  i, 8'(bus.loss),       8'(vecs[i].loss));
         check({vecs[i].name, ".rr"},    i, 8'(bus.ring_reset), 8'(vecs[i].rr));
         check({vecs[i].name, ".dv"},    i, 8'(bus.dlv_valid),  8'(vecs[i].dv));
         check({vecs[i].name, ".count"}, i, 8'(bus.count),      8'(vecs[i].cnt));
         check({vecs[i].name, ".full"},  i, 8'(bus.full),       8'(vecs[i].full));
         check({vecs[i].name, ".error"}, i, 8'(bus.error),      8'(vecs[i].err));
         if (bus.dlv_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check({vecs[i].name, ".unexpected_dlv"}, i, 8'(bus.dlv_seq), 8'hff);
            end else begin
               check({vecs[i].name, ".dlv_seq"}, i, 8'(bus.dlv_seq), 8'(exp_q.pop_front()));
            end
         end
         if (vecs[i].rst) begin
            check("reset.dlv_seq", i, 8'(bus.dlv_seq), 8'h00);
            check("scoreboard_drained", i, 8'(exp_q.size()), 8'h00);
            exp_q.delete();
         end
      end

      reset    = 1'b0;
      bus.send = 1'b0;
      bus.drop = 1'b0;
      check("final_drained", vecs.size(), 8'(exp_q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // dlv_valid and ring_reset must never coincide.
   always @(negedge clk) begin
      if (!reset && bus.dlv_valid === 1'b1) begin
         check("dv_rr_exclusive", -1, 8'(bus.ring_reset), 8'h00);
      end
   end

endmodule
